// File: rtl/ifetch_pkg.sv
// ----------------------------------------------------------------------------
// ifetch_pkg
// Shared definitions for the instruction fetch unit:
//   - ADDR_W / INST_W : address and instruction widths (32)
//   - PC_INC          : sequential fetch increment (4)
//   - ifetch_state_e  : fetch control states (RUN, DRAIN)
//   - ifetch_entry_t  : one instruction queue entry {pc, data}
//   - align_pc()      : force a PC onto a 4-byte boundary
// ----------------------------------------------------------------------------
package ifetch_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [ADDR_W-1:0] PC_INC = 32'd4;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } ifetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] data;
  } ifetch_entry_t;

  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
    return pc & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/ifetch_queue.sv
// ----------------------------------------------------------------------------
// ifetch_queue
// Small FIFO of fetched instructions ({pc, data}) between the memory response
// path and the decode interface.
//   clk, rst_n     : clock, asynchronous active-low reset
//   flush_i        : drop all entries (wins over push/pop in the same cycle)
//   push_i         : write push_entry_i (accepted when not full, or when full
//                    and a pop happens in the same cycle)
//   pop_i          : remove the head entry (ignored when empty)
//   head_o         : current head entry (content undefined when empty)
//   full_o/empty_o : occupancy flags
//   count_o        : number of valid entries
// ----------------------------------------------------------------------------
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  ifetch_entry_t          push_entry_i,
  input  logic                   pop_i,
  output ifetch_entry_t          head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned    PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  ifetch_entry_t  mem_q [DEPTH];
  logic [PTR_W:0] rd_ptr_q;
  logic [PTR_W:0] wr_ptr_q;
  logic           do_push;
  logic           do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (count_o == FULL_CNT);

  assign do_pop  = pop_i & ~empty_o;
  // A full queue can still take a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= push_entry_i;
    end
  end

  assign head_o = mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
// Sequential instruction fetcher with redirect support and an instruction
// queue towards decode.
//   Parameters : RESET_PC (first fetch address), QUEUE_DEPTH (2..8, pow2)
//   clk, rst_n                              : clock, async active-low reset
//   imem_req_valid/ready, imem_req_addr     : memory request handshake
//   imem_resp_valid, imem_resp_data         : in-order responses, no stall
//   redirect_valid, redirect_pc             : new fetch target from the CPU
//   inst_valid/ready, inst_data, inst_pc,
//   inst_pc_plus4                           : instruction towards decode
// Optional build macro IFETCH_PERF_EN adds:
//   perf_fetched : instructions handed to decode (wrapping)
//   perf_stall   : cycles decode was ready but no instruction was available
// ----------------------------------------------------------------------------
module instruction_fetch
  import ifetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned       QUEUE_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] inst_pc_plus4
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);

  localparam int unsigned      CNT_W     = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CNT_W:0]   DEPTH_LIM = (CNT_W + 1)'(QUEUE_DEPTH);

  if (QUEUE_DEPTH < 2 || QUEUE_DEPTH > 8 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("instruction_fetch: QUEUE_DEPTH must be a power of two in 2..8");
  end

  ifetch_state_e     state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  outst_q, outst_d;   // accepted requests awaiting a response
  logic              run_en_q;          // first cycle after reset issues nothing

  logic              accept;
  logic              resp_fire;
  logic              pop_raw;
  logic              credit_ok;
  logic [CNT_W:0]    inflight;
  logic [ADDR_W-1:0] resp_pc;

  logic              q_flush;
  logic              q_push;
  ifetch_entry_t     q_push_entry;
  ifetch_entry_t     q_head;
  logic              q_full;
  logic              q_empty;
  logic [CNT_W-1:0]  q_count;

  // --------------------------------------------------------------------------
  // Request side
  // --------------------------------------------------------------------------
  // An entry leaving the queue this cycle frees its slot, so a steady stream
  // with single-cycle memory keeps one instruction per cycle flowing.
  assign inflight  = {1'b0, q_count} - (CNT_W + 1)'(pop_raw) + {1'b0, outst_q};
  assign credit_ok = (inflight < DEPTH_LIM);

  assign imem_req_valid = run_en_q && (state_q == ST_RUN) && credit_ok;
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid & imem_req_ready;

  // Responses with nothing outstanding are leftovers from before a reset.
  assign resp_fire = imem_resp_valid && (outst_q != '0);

  // Outstanding requests are always consecutive, so the oldest one (the one
  // this response belongs to) sits that many words behind the fetch PC.
  assign resp_pc = fetch_pc_q - ADDR_W'({outst_q, 2'b00});

  assign q_push_entry = '{pc: resp_pc, data: imem_resp_data};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = accept ? (fetch_pc_q + PC_INC) : fetch_pc_q;
    outst_d    = outst_q + CNT_W'(accept) - CNT_W'(resp_fire);
    q_flush    = 1'b0;
    q_push     = 1'b0;

    if (redirect_valid) begin
      // Everything still in flight now belongs to the old path and must be
      // discarded as it returns.
      q_flush    = 1'b1;
      fetch_pc_d = align_pc(redirect_pc);
      state_d    = (outst_d != '0) ? ST_DRAIN : ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          q_push = resp_fire && (!q_full || pop_raw);
        end
        ST_DRAIN: begin
          if (outst_d == '0) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      run_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      run_en_q   <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Instruction queue and decode side
  // --------------------------------------------------------------------------
  assign pop_raw = inst_valid & inst_ready;

  ifetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (q_flush),
    .push_i       (q_push),
    .push_entry_i (q_push_entry),
    .pop_i        (pop_raw),
    .head_o       (q_head),
    .full_o       (q_full),
    .empty_o      (q_empty),
    .count_o      (q_count)
  );

  assign inst_valid    = ~q_empty;
  // Zero the payload while empty so decode never sees stale storage.
  assign inst_data     = q_empty ? '0 : q_head.data;
  assign inst_pc       = q_empty ? '0 : q_head.pc;
  assign inst_pc_plus4 = inst_pc + PC_INC;

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      // A handshake in a redirect cycle is squashed along with the queue.
      if (pop_raw && !redirect_valid) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (inst_ready && !inst_valid)  perf_stall_q   <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  always #5 clk = ~clk;

  instruction_fetch #(
    .RESET_PC    (RESET_PC),
    .QUEUE_DEPTH (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .inst_pc_plus4   (inst_pc_plus4)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_stall      (perf_stall)
`endif
  );

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int n_inst  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A5A_C3C3;
  endfunction

  // Memory model: accepted requests, each with the cycle its response is due.
  typedef struct { logic [31:0] addr; int due; } mresp_t;
  mresp_t mem_q[$];
  // Scoreboard: instructions decode must receive, in order.
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
  exp_t sb_q[$];

  logic [31:0] exp_fetch;
  int          drain_left;
  int          lat_min = 1;
  int          lat_max = 1;
  int          last_due;
  bit          prev_redirect, prev_hold, prev_req_hold;
  logic [31:0] prev_pc, prev_data, prev_addr;
  int          exp_fetched, exp_stall;

  // One clock cycle: check and account the current cycle, then move on to the
  // next cycle and drive the memory response for it. Returns at the negedge.
  task automatic tick();
    bit     acc;
    int     due;
    exp_t   e;
    mresp_t m;
    #1;
    if (prev_redirect) check_eq("inst_valid_after_redirect", 32'(inst_valid), 32'd0);
    if (prev_hold) begin
      check_eq("hold_valid", 32'(inst_valid), 32'd1);
      check_eq("hold_pc", inst_pc, prev_pc);
      check_eq("hold_data", inst_data, prev_data);
    end
    if (prev_req_hold && imem_req_valid) check_eq("req_addr_hold", imem_req_addr, prev_addr);
    if (drain_left > 0) check_eq("req_in_drain", 32'(imem_req_valid), 32'd0);

    acc = imem_req_valid && imem_req_ready;
    if (acc) begin
      check_eq("req_addr", imem_req_addr, exp_fetch);
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      m.addr = exp_fetch;
      m.due  = due;
      mem_q.push_back(m);
      if (!redirect_valid) begin
        e.pc   = exp_fetch;
        e.data = mem_data(exp_fetch);
        sb_q.push_back(e);
      end
      exp_fetch = exp_fetch + 32'd4;
    end

    if (inst_valid && inst_ready && !redirect_valid) begin
      check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check_eq("inst_pc", inst_pc, e.pc);
        check_eq("inst_data", inst_data, e.data);
        check_eq("inst_pc_plus4", inst_pc_plus4, e.pc + 32'd4);
        $display("inst pc=%h data=%h pc4=%h cycle=%0d", inst_pc, inst_data, inst_pc_plus4, cyc);
      end
      n_inst++;
      exp_fetched++;
    end
    if (inst_ready && !inst_valid) exp_stall++;

    if (redirect_valid) begin
      sb_q.delete();
      exp_fetch  = redirect_pc & ~32'h3;
      drain_left = mem_q.size();
    end else if (drain_left > 0 && imem_resp_valid) begin
      drain_left--;
    end

    prev_redirect = redirect_valid;
    prev_hold     = inst_valid && !inst_ready && !redirect_valid;
    prev_pc       = inst_pc;
    prev_data     = inst_data;
    prev_req_hold = imem_req_valid && !imem_req_ready && !redirect_valid;
    prev_addr     = imem_req_addr;

    @(posedge clk);
    #1;
    cyc++;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_data(m.addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    @(negedge clk);
  endtask

  task automatic redirect_to(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_pc    = a;
    tick();
    redirect_valid = 1'b0;
    redirect_pc    = $urandom;
  endtask

  // Asserts reset mid-cycle, checks the reset state, releases at a negedge
  // with a stale memory response on the bus that must be ignored.
  task automatic do_reset();
    rst_n = 1'b0;
    imem_resp_valid = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check_eq("rst_inst_valid", 32'(inst_valid), 32'd0);
      check_eq("rst_inst_data", inst_data, 32'd0);
      check_eq("rst_inst_pc", inst_pc, 32'd0);
`ifdef IFETCH_PERF_EN
      check_eq("rst_perf_fetched", perf_fetched, 32'd0);
      check_eq("rst_perf_stall", perf_stall, 32'd0);
`endif
      @(posedge clk);
      #1;
    end
    mem_q.delete();
    sb_q.delete();
    exp_fetch     = RESET_PC;
    drain_left    = 0;
    last_due      = cyc;
    prev_redirect = 0;
    prev_hold     = 0;
    prev_req_hold = 0;
    exp_fetched   = 0;
    exp_stall     = 0;
    @(negedge clk);
    rst_n           = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hBAD0_BAD0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b1;
    @(negedge clk);
    do_reset();

    // Sequential stream after reset: one instruction per cycle once started.
    for (int i = 0; i < 12; i++) begin
      if (i == 3) check_eq("first_inst_pc", inst_pc, RESET_PC);
      if (i >= 3) check_eq("stream_valid", 32'(inst_valid), 32'd1);
      tick();
    end

    // Decode stall: queue fills, requests stop, head held; then drain.
    inst_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check_eq("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("stall_inst_valid", 32'(inst_valid), 32'd1);
    inst_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();

    // Redirect to an unaligned target with two requests outstanding.
    lat_min = 3;
    lat_max = 3;
    for (int i = 0; i < 20 && mem_q.size() != 2; i++) tick();
    check_eq("t31_outstanding", 32'(mem_q.size()), 32'd2);
    redirect_to(32'h0000_0103);
    lat_min = 1;
    lat_max = 1;
    for (int i = 0; i < 20 && !imem_req_valid; i++) tick();
    check_eq("t31_req_valid", 32'(imem_req_valid), 32'd1);
    check_eq("t31_req_addr", imem_req_addr, 32'h0000_0100);
    for (int i = 0; i < 20 && !inst_valid; i++) tick();
    check_eq("t31_inst_pc", inst_pc, 32'h0000_0100);
    for (int i = 0; i < 6; i++) tick();

    // Redirect in the same cycle as a response and a pop.
    for (int i = 0; i < 20 && !(imem_resp_valid && inst_valid); i++) tick();
    check_eq("t32_setup", 32'(imem_resp_valid && inst_valid), 32'd1);
    redirect_to(32'h0000_0200);
    check_eq("t32_empty", 32'(inst_valid), 32'd0);
    for (int i = 0; i < 6; i++) tick();

    // Fetch PC wrap at the top of the address space.
    redirect_to(32'hFFFF_FFFC);
    for (int i = 0; i < 20 && !inst_valid; i++) tick();
    check_eq("t33_pc", inst_pc, 32'hFFFF_FFFC);
    check_eq("t33_pc_plus4", inst_pc_plus4, 32'h0000_0000);
    tick();
    for (int i = 0; i < 20 && !inst_valid; i++) tick();
    check_eq("t33_wrap_pc", inst_pc, 32'h0000_0000);
    for (int i = 0; i < 4; i++) tick();

    // Randomised traffic: latency, both readies and occasional redirects.
    lat_max = 4;
    for (int i = 0; i < 300; i++) begin
      inst_ready     = ($urandom_range(3, 0) != 0);
      imem_req_ready = ($urandom_range(3, 0) != 0);
      if ($urandom_range(29, 0) == 0) redirect_to($urandom);
      else tick();
    end
    inst_ready     = 1'b1;
    imem_req_ready = 1'b1;

`ifdef IFETCH_PERF_EN
    check_eq("perf_fetched", perf_fetched, 32'(exp_fetched));
    check_eq("perf_stall", perf_stall, 32'(exp_stall));
`endif

    // Reset in the middle of traffic, then refetch from RESET_PC.
    tick();
    do_reset();
    lat_min = 1;
    lat_max = 1;
    for (int i = 0; i < 20 && !inst_valid; i++) tick();
    check_eq("rerst_inst_pc", inst_pc, RESET_PC);
    for (int i = 0; i < 10; i++) tick();

`ifdef IFETCH_PERF_EN
    check_eq("perf_fetched_end", perf_fetched, 32'(exp_fetched));
    check_eq("perf_stall_end", perf_stall, 32'(exp_stall));
`endif
    check_eq("inst_count_min", 32'(n_inst > 40), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
